// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb object stage: FSM states,
// grid geometry, palette, and a small signed helper used by the hit test.
package bomb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    EXPLODING = 2'd2,
    COOLDOWN  = 2'd3
  } bomb_state_t;

  localparam int TILE_SHIFT = 5;
  localparam int GRID_COLS  = 20;
  localparam int GRID_ROWS  = 15;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;

  localparam logic [7:0] BOMB_BLACK  = 8'h00;
  localparam logic [7:0] BOMB_RED    = 8'hE0;
  localparam logic [7:0] BLAST_CORE  = 8'hFC;
  localparam logic [7:0] BLAST_ARM   = 8'hF0;
  localparam logic [7:0] TRANSPARENT = 8'hFF;

  // Magnitude of a 6-bit signed tile distance; -32 never occurs on this grid.
  function automatic logic [5:0] tile_abs(input logic signed [5:0] d);
    return d[5] ? 6'(-d) : 6'(d);
  endfunction

endpackage

// File: rtl/bomb_unit_if.sv
// Bus between the game/VGA side and the bomb stage: frame timing, key,
// player position and pixel scan in; drawing request and bomb state out.
interface bomb_unit_if;

  logic        startOfFrame;
  logic        placeBomb;
  logic [10:0] playerTopLeftX;
  logic [10:0] playerTopLeftY;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        bombDR;
  logic [7:0]  bombRGB;
  logic        bombActive;
  logic        explosionActive;
  logic [4:0]  bombTileX;
  logic [3:0]  bombTileY;

  // Game / video-timing side.
  modport master (
    output startOfFrame, placeBomb, playerTopLeftX, playerTopLeftY, pixelX, pixelY,
    input  bombDR, bombRGB, bombActive, explosionActive, bombTileX, bombTileY
  );

  // Bomb stage side.
  modport slave (
    input  startOfFrame, placeBomb, playerTopLeftX, playerTopLeftY, pixelX, pixelY,
    output bombDR, bombRGB, bombActive, explosionActive, bombTileX, bombTileY
  );

endinterface

// File: rtl/blast_hit_test.sv
// Combinational test of whether a pixel's tile lies on the blast cross
// centred on the bomb tile, and whether it is the centre tile itself.
// Arms are naturally clipped because pixel tiles never leave the grid.
module blast_hit_test
  import bomb_pkg::*;
(
  input  logic [4:0] pix_tile_x,
  input  logic [4:0] pix_tile_y,
  input  logic [4:0] bomb_tile_x,
  input  logic [3:0] bomb_tile_y,
  input  logic [2:0] range,
  output logic [1:0] hit
);

  logic signed [5:0] dx;
  logic signed [5:0] dy;
  logic [5:0]        adx;
  logic [5:0]        ady;
  logic [5:0]        range_ext;
  logic              same_row;
  logic              same_col;
  logic              in_cross;
  logic              is_centre;

  // Signed tile distances and the cross membership test.
  always_comb begin
    dx        = $signed({1'b0, pix_tile_x}) - $signed({1'b0, bomb_tile_x});
    dy        = $signed({1'b0, pix_tile_y}) - $signed({2'b00, bomb_tile_y});
    adx       = tile_abs(dx);
    ady       = tile_abs(dy);
    range_ext = {3'b000, range};
    same_row  = (dy == 6'sd0);
    same_col  = (dx == 6'sd0);
    in_cross  = (same_row && (adx <= range_ext)) || (same_col && (ady <= range_ext));
    is_centre = same_row && same_col;
    hit       = {in_cross, is_centre};
  end

endmodule

// File: rtl/bomb_unit.sv
// Single player bomb: captures the place-key edge, runs the fuse / blast /
// cooldown sequence on frame pulses, and answers each pixel one clock later
// with the bomb or blast drawing request and colour.
module bomb_unit
  import bomb_pkg::*;
#(
  parameter int FUSE_FRAMES     = 120,
  parameter int BLINK_FRAMES    = 30,
  parameter int EXPLODE_FRAMES  = 30,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int BLAST_RANGE     = 2
) (
  input logic        clk,
  input logic        resetN,
  bomb_unit_if.slave bus
);

  localparam int MAX_LOAD_A = (FUSE_FRAMES > EXPLODE_FRAMES) ? FUSE_FRAMES : EXPLODE_FRAMES;
  localparam int MAX_LOAD   = (MAX_LOAD_A > COOLDOWN_FRAMES) ? MAX_LOAD_A : COOLDOWN_FRAMES;
  localparam int CNT_RAW    = $clog2(MAX_LOAD + 1);
  // frameCnt[3] drives the blink, so keep at least four bits.
  localparam int CNT_W      = (CNT_RAW < 4) ? 4 : CNT_RAW;

  localparam logic [CNT_W-1:0] FUSE_LOAD     = CNT_W'(FUSE_FRAMES - 1);
  localparam logic [CNT_W-1:0] EXPLODE_LOAD  = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] BLINK_LIMIT   = CNT_W'(BLINK_FRAMES);
  localparam logic [2:0]       RANGE         = 3'(BLAST_RANGE);

  // Tile under the player's centre, saturated to the last column/row.
  function automatic logic [4:0] centre_tile(input logic [10:0] pos, input int limit);
    logic [11:0] centre;
    logic [6:0]  t;
    centre = {1'b0, pos} + 12'd16;
    t      = centre[11:TILE_SHIFT];
    if (t > 7'(limit)) return 5'(limit);
    else               return t[4:0];
  endfunction

  bomb_state_t      state;
  logic [CNT_W-1:0] frame_cnt;
  logic             pending;
  logic             place_q;
  logic [4:0]       tile_x;
  logic [3:0]       tile_y;
  logic             bomb_active;
  logic             explosion_active;
  logic             dr_p1;
  logic [7:0]       rgb_p1;

  logic             place_edge;
  logic [4:0]       cand_x;
  logic [4:0]       cand_y_full;
  logic [3:0]       cand_y;

  assign place_edge  = bus.placeBomb & ~place_q;
  assign cand_x      = centre_tile(bus.playerTopLeftX, GRID_COLS - 1);
  assign cand_y_full = centre_tile(bus.playerTopLeftY, GRID_ROWS - 1);
  assign cand_y      = cand_y_full[3:0];

  // Key capture and the frame-stepped bomb life cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state            <= IDLE;
      frame_cnt        <= '0;
      pending          <= 1'b0;
      place_q          <= 1'b0;
      tile_x           <= '0;
      tile_y           <= '0;
      bomb_active      <= 1'b0;
      explosion_active <= 1'b0;
    end else begin
      place_q <= bus.placeBomb;
      case (state)
        IDLE: begin
          if (bus.startOfFrame && (pending || place_edge)) begin
            state       <= ARMED;
            frame_cnt   <= FUSE_LOAD;
            tile_x      <= cand_x;
            tile_y      <= cand_y;
            pending     <= 1'b0;
            bomb_active <= 1'b1;
          end else if (place_edge) begin
            pending <= 1'b1;
          end
        end
        ARMED: begin
          pending <= 1'b0;
          if (bus.startOfFrame) begin
            if (frame_cnt == '0) begin
              state            <= EXPLODING;
              frame_cnt        <= EXPLODE_LOAD;
              explosion_active <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt - 1'b1;
            end
          end
        end
        EXPLODING: begin
          pending <= 1'b0;
          if (bus.startOfFrame) begin
            if (frame_cnt == '0) begin
              state            <= COOLDOWN;
              frame_cnt        <= COOLDOWN_LOAD;
              bomb_active      <= 1'b0;
              explosion_active <= 1'b0;
            end else begin
              frame_cnt <= frame_cnt - 1'b1;
            end
          end
        end
        COOLDOWN: begin
          pending <= 1'b0;
          if (bus.startOfFrame) begin
            if (frame_cnt == '0) state <= IDLE;
            else                 frame_cnt <= frame_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0: combinational pixel evaluation ----
  logic       on_screen_p0;
  logic [4:0] pix_tile_x_p0;
  logic [4:0] pix_tile_y_p0;
  logic [4:0] off_x_p0;
  logic [4:0] off_y_p0;
  logic       in_bomb_tile_p0;
  logic       in_body_p0;
  logic       blink_p0;
  logic [1:0] hit_p0;
  logic       dr_p0;
  logic [7:0] rgb_p0;

  assign pix_tile_x_p0 = bus.pixelX[9:5];
  assign pix_tile_y_p0 = bus.pixelY[9:5];
  assign off_x_p0      = bus.pixelX[4:0];
  assign off_y_p0      = bus.pixelY[4:0];

  blast_hit_test u_hit (
    .pix_tile_x  (pix_tile_x_p0),
    .pix_tile_y  (pix_tile_y_p0),
    .bomb_tile_x (tile_x),
    .bomb_tile_y (tile_y),
    .range       (RANGE),
    .hit         (hit_p0)
  );

  // Decide draw request and colour for the current pixel.
  always_comb begin
    on_screen_p0    = (bus.pixelX < 11'(SCREEN_W)) && (bus.pixelY < 11'(SCREEN_H));
    in_bomb_tile_p0 = (pix_tile_x_p0 == tile_x) && (pix_tile_y_p0 == {1'b0, tile_y});
    in_body_p0      = (off_x_p0 >= 5'd4) && (off_x_p0 <= 5'd27) &&
                      (off_y_p0 >= 5'd4) && (off_y_p0 <= 5'd27);
    blink_p0        = (frame_cnt < BLINK_LIMIT) && frame_cnt[3];
    dr_p0           = 1'b0;
    rgb_p0          = TRANSPARENT;
    case (state)
      ARMED: begin
        if (on_screen_p0 && in_bomb_tile_p0 && in_body_p0) begin
          dr_p0  = 1'b1;
          rgb_p0 = blink_p0 ? BOMB_RED : BOMB_BLACK;
        end
      end
      EXPLODING: begin
        if (on_screen_p0 && hit_p0[1]) begin
          dr_p0  = 1'b1;
          rgb_p0 = hit_p0[0] ? BLAST_CORE : BLAST_ARM;
        end
      end
      default: begin
        dr_p0  = 1'b0;
        rgb_p0 = TRANSPARENT;
      end
    endcase
  end

  // ---- stage p1: registered drawing outputs ----
  // Register the pixel answer so it lines up with the other drawers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      dr_p1  <= 1'b0;
      rgb_p1 <= TRANSPARENT;
    end else begin
      dr_p1  <= dr_p0;
      rgb_p1 <= rgb_p0;
    end
  end

  assign bus.bombDR          = dr_p1;
  assign bus.bombRGB         = rgb_p1;
  assign bus.bombActive      = bomb_active;
  assign bus.explosionActive = explosion_active;
  assign bus.bombTileX       = tile_x;
  assign bus.bombTileY       = tile_y;

endmodule

// File: doc/bomb_unit.md
# bomb_unit

Upstream object stage for the VGA object mixer: owns the single player bomb from placement through fuse countdown and explosion. Per pixel, it produces the bomb/blast drawing request and colour that the mixer ranks second, below the player. It also publishes bomb state and blast geometry for game logic. Time advances on frame pulses and pixels are answered with one clock of latency, matching the other drawers.

## Interface
- FUSE_FRAMES, 120: frames from arming to explosion.
- BLINK_FRAMES, 30: final fuse frames during which the bomb blinks.
- EXPLODE_FRAMES, 30: frames the blast stays visible.
- COOLDOWN_FRAMES, 15: frames after the blast before a new bomb is accepted.
- BLAST_RANGE, 2: blast arm length in tiles (1..7).
- clk  in  1  pixel clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per frame.
- placeBomb  in  1  key level; the rising edge requests a bomb.
- playerTopLeftX  in  11  player X in pixels, 0..639.
- playerTopLeftY  in  11  player Y in pixels, 0..479.
- pixelX  in  11  current pixel X.
- pixelY  in  11  current pixel Y.
- bombDR  out  1  drawing request to the mixer.
- bombRGB  out  8  RRRGGGBB colour.
- bombActive  out  1  high in ARMED or EXPLODING.
- explosionActive  out  1  high in EXPLODING.
- bombTileX  out  5  bomb column, 0..19.
- bombTileY  out  4  bomb row, 0..14.

## Operation
**Grid**
- 32×32 tiles, 20 columns × 15 rows.
- Bomb tile is computed from the player centre: tileX = (playerTopLeftX+16)>>5 and tileY = (playerTopLeftY+16)>>5.
- tileX is clamped to 19 and tileY to 14.

**Request capture**
- placeBomb is registered and a rising edge sets `pending`.
- `pending` clears when the bomb is consumed by IDLE→ARMED.
- `pending` also clears when it is ignored: any edge seen outside IDLE is dropped, with no queuing.

**State machine**
All transitions happen only on startOfFrame.
- IDLE → ARMED when `pending` is set, including an edge arriving in the same cycle. On this transition the tile is latched and frameCnt loads FUSE_FRAMES-1.
- ARMED: frameCnt decrements each frame. At 0 → EXPLODING and frameCnt loads EXPLODE_FRAMES-1.
- EXPLODING: frameCnt decrements. At 0 → COOLDOWN and frameCnt loads COOLDOWN_FRAMES-1.
- COOLDOWN: frameCnt decrements. At 0 → IDLE.

**Drawing**
- Evaluated combinationally from pixelX/pixelY and registered to the outputs.
- Pixels with X ≥ 640 or Y ≥ 480 → bombDR = 0.
- Pixel tile is pixelX[9:5], pixelY[9:5]; in-tile offset is bits [4:0].
- ARMED: draw when the pixel is in the bomb tile and both offsets are in 4..27.
  - Colour is 8'h00.
  - In the last BLINK_FRAMES frames (frameCnt < BLINK_FRAMES), frameCnt[3] = 1 selects 8'hE0 instead.
- EXPLODING: draw when the pixel tile is in the blast cross.
  - Cross = same row with |dx| ≤ BLAST_RANGE, or same column with |dy| ≤ BLAST_RANGE.
  - dx and dy use 6-bit signed arithmetic.
  - Centre tile colour is 8'hFC; arm tiles are 8'hF0.
  - Arms are clipped by the grid bounds; there is no wrap-around.
- IDLE and COOLDOWN: bombDR = 0.
- bombRGB is don't-care when bombDR = 0, but is driven to 8'hFF.

**Reset**
- Asynchronous. Sets IDLE, frameCnt 0, `pending` 0, bombDR 0, bombRGB 8'hFF, bombActive 0, explosionActive 0, bombTileX 0, bombTileY 0.
- Reset mid-fuse or mid-blast discards the bomb immediately.

## Timing
- bombDR and bombRGB appear 1 clk after the corresponding pixelX/pixelY.
- State, bombActive, explosionActive and the tile outputs are registered.
- They change the clk after the startOfFrame cycle that triggers them.
- Total ARMED time is exactly FUSE_FRAMES frames.
- Total EXPLODING time is EXPLODE_FRAMES frames; total COOLDOWN time is COOLDOWN_FRAMES frames.
- A player moving during ARMED does not move the bomb; the tile is latched once.

## Structure
- Package bomb_pkg holds:
  - the state enum (IDLE, ARMED, EXPLODING, COOLDOWN);
  - TILE_SHIFT = 5, GRID_COLS = 20, GRID_ROWS = 15;
  - colour constants BOMB_BLACK, BOMB_RED, BLAST_CORE, BLAST_ARM, TRANSPARENT.
- Sub-module blast_hit_test (combinational) takes the pixel tile, bomb tile and range and returns {inCross, isCentre}.

## Test plan
- Player at (100,200), placeBomb edge, then startOfFrame → bombTileX = 3, bombTileY = 6, ARMED. Pixel (100,196) gives bombDR = 1, RGB 8'h00 one clk later. Pixel (96,192) gives bombDR = 0.
- After 90 frames → frameCnt = 29 (bit3 = 1), RGB 8'hE0. At 120 frames → explosionActive = 1. Pixel in tile (5,6) gives 8'hF0; pixel in tile (6,6) gives bombDR = 0.
- Bomb at tile (0,0), EXPLODING: tiles (0,2) and (2,0) are drawn, the centre is 8'hFC, no pixel at X ≥ 608 is drawn, and pixel (640,0) gives bombDR = 0.
- placeBomb edges during ARMED, EXPLODING and COOLDOWN → ignored. An edge in the same cycle as the startOfFrame that enters IDLE is still dropped. An edge in IDLE re-arms at the next startOfFrame.
- placeBomb edge coinciding with startOfFrame in IDLE → ARMED on the next clk. Holding the key high for 500 frames arms once only.
- resetN low for 3 clks mid-EXPLODING → all outputs at their reset values asynchronously. No explosion resumes after release.
